adler32_msg_framer: RTL and testbench

//  Transmit side of the adler32 message interface: buffers one message arriving on a

---
 rtl/adler32_msg_framer_pkg.sv | 16 +
 rtl/adler32_msg_framer_if.sv | 28 ++
 rtl/adler32_msg_framer_msg_buf.sv | 31 +++
 rtl/adler32_msg_framer.sv | 138 +++++++++++++
 tb/tb_adler32_msg_framer.sv | 360 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adler32_msg_framer_pkg.sv
// Shared widths and FSM encoding for the adler32 message framer.
// Imported by the framer, its buffer and the bus interface.
package adler32_msg_framer_pkg;

   localparam int SIZE_W = 32;
   localparam int BYTE_W = 8;

   typedef enum logic [2:0] {
      ST_FILL,
      ST_SIZE,
      ST_DATA,
      ST_GAP,
      ST_WAIT
   } state_t;

endpackage

// File: rtl/adler32_msg_framer_if.sv
// Byte-stream input, framed message output and checksum strobe of the framer.
// The slave side is the framer; the master side is the byte source plus adler32 block.
interface adler32_msg_framer_if;
   import adler32_msg_framer_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic [BYTE_W-1:0] in_data;
   logic              in_last;
   logic              size_valid;
   logic [SIZE_W-1:0] size;
   logic              data_start;
   logic [BYTE_W-1:0] data;
   logic              checksum_valid;
   logic              busy;
   logic              trunc;

   modport master (
      output in_valid, in_data, in_last, checksum_valid,
      input  in_ready, size_valid, size, data_start, data, busy, trunc
   );

   modport slave (
      input  in_valid, in_data, in_last, checksum_valid,
      output in_ready, size_valid, size, data_start, data, busy, trunc
   );

endinterface

// File: rtl/adler32_msg_framer_msg_buf.sv
// Message buffer: DEPTH x 8 RAM, one write port, one registered read port.
// The read register is reset so the framer's data output starts at zero.
module adler32_msg_framer_msg_buf
   import adler32_msg_framer_pkg::*;
#(
   parameter int DEPTH = 256,
   parameter int AW    = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [BYTE_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [AW-1:0]     rd_addr,
   output logic [BYTE_W-1:0] rd_data
);

   logic [BYTE_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   // Read data holds between reads, which keeps the last byte visible after a message.
   always_ff @(posedge clk) begin
      if (rst)        rd_data <= '0;
      else if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/adler32_msg_framer.sv
// Buffers one message from a valid/ready byte stream and replays it to the adler32
// block as a size pulse followed by a contiguous data burst.
module adler32_msg_framer
   import adler32_msg_framer_pkg::*;
#(
   parameter int DEPTH      = 256,
   parameter int AW         = 8,
   parameter int WAIT_CKSUM = 1,
   parameter int GAP        = 0
) (
   input logic                  clock,
   input logic                  rst,
   adler32_msg_framer_if.slave  bus
);

   localparam logic [AW:0] LAST_IDX = (AW+1)'(DEPTH - 1);

   state_t            state;
   logic [AW:0]       count;
   logic [AW:0]       rd_ptr;
   logic [3:0]        gap_cnt;
   logic              in_ready_q;
   logic              busy_q;
   logic              size_valid_q;
   logic              data_start_q;
   logic [SIZE_W-1:0] size_q;
   logic [BYTE_W-1:0] rd_data;
   logic              fire;
   logic              last_slot;
   logic              closing;
   logic              rd_en;

   assign fire      = bus.in_valid & in_ready_q;
   assign last_slot = (count == LAST_IDX);
   assign closing   = fire & (bus.in_last | last_slot);

   // Buffer is read one cycle ahead: address 0 in SIZE, then rd_ptr through DATA.
   assign rd_en = (state == ST_SIZE) || ((state == ST_DATA) && (rd_ptr != count));

   adler32_msg_framer_msg_buf #(.DEPTH(DEPTH), .AW(AW)) u_buf (
      .clk     (clock),
      .rst     (rst),
      .wr_en   (fire),
      .wr_addr (count[AW-1:0]),
      .wr_data (bus.in_data),
      .rd_en   (rd_en),
      .rd_addr (rd_ptr[AW-1:0]),
      .rd_data (rd_data)
   );

   always_ff @(posedge clock) begin
      if (rst) begin
         state        <= ST_FILL;
         count        <= '0;
         rd_ptr       <= '0;
         gap_cnt      <= '0;
         in_ready_q   <= 1'b1;
         busy_q       <= 1'b0;
         size_valid_q <= 1'b0;
         data_start_q <= 1'b0;
         size_q       <= '0;
      end else begin
         size_valid_q <= 1'b0;
         data_start_q <= 1'b0;
         unique case (state)
            ST_FILL: begin
               if (fire) begin
                  count <= count + 1'b1;
                  if (closing) begin
                     state        <= ST_SIZE;
                     in_ready_q   <= 1'b0;
                     busy_q       <= 1'b1;
                     size_valid_q <= 1'b1;
                     size_q       <= SIZE_W'(count + 1'b1);
                     rd_ptr       <= '0;
                  end
               end
            end
            ST_SIZE: begin
               state        <= ST_DATA;
               data_start_q <= 1'b1;
               rd_ptr       <= rd_ptr + 1'b1;
            end
            ST_DATA: begin
               // rd_ptr reaching count means the byte on data now is the last one.
               if (rd_ptr == count) begin
                  if (GAP > 0) begin
                     state   <= ST_GAP;
                     gap_cnt <= 4'(GAP - 1);
                  end else if (WAIT_CKSUM != 0) begin
                     state <= ST_WAIT;
                  end else begin
                     state      <= ST_FILL;
                     count      <= '0;
                     in_ready_q <= 1'b1;
                     busy_q     <= 1'b0;
                  end
               end else begin
                  rd_ptr <= rd_ptr + 1'b1;
               end
            end
            ST_GAP: begin
               if (gap_cnt == '0) begin
                  if (WAIT_CKSUM != 0) begin
                     state <= ST_WAIT;
                  end else begin
                     state      <= ST_FILL;
                     count      <= '0;
                     in_ready_q <= 1'b1;
                     busy_q     <= 1'b0;
                  end
               end else begin
                  gap_cnt <= gap_cnt - 1'b1;
               end
            end
            ST_WAIT: begin
               if (bus.checksum_valid) begin
                  state      <= ST_FILL;
                  count      <= '0;
                  in_ready_q <= 1'b1;
                  busy_q     <= 1'b0;
               end
            end
            default: state <= ST_FILL;
         endcase
      end
   end

   assign bus.in_ready   = in_ready_q;
   assign bus.busy       = busy_q;
   assign bus.size_valid = size_valid_q;
   assign bus.size       = size_q;
   assign bus.data_start = data_start_q;
   assign bus.data       = rd_data;
   // Force-close flag is flagged on the accepting cycle itself.
   assign bus.trunc      = ~rst & fire & ~bus.in_last & last_slot;

endmodule

// File: tb/tb_adler32_msg_framer.sv
// Bench for adler32_msg_framer: u0 (DEPTH=256, checksum wait, no gap) and
// u1 (DEPTH=4, no checksum wait, GAP=3); framed output is rebuilt and checksummed.
module tb_adler32_msg_framer;

   typedef struct {
      string       msg;
      int          pct;
      logic [31:0] size;
      logic [31:0] ck;
   } vec_t;

   typedef struct {
      logic [31:0] size;
      logic [31:0] ck;
      int          t_sv;
      int          t_ds;
      int          t_end;
   } rec_t;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   adler32_msg_framer_if if0 ();
   adler32_msg_framer_if if1 ();

   adler32_msg_framer #(.DEPTH(256), .AW(8), .WAIT_CKSUM(1), .GAP(0)) u0 (
      .clock (clk),
      .rst   (rst),
      .bus   (if0.slave)
   );

   adler32_msg_framer #(.DEPTH(4), .AW(2), .WAIT_CKSUM(0), .GAP(3)) u1 (
      .clock (clk),
      .rst   (rst),
      .bus   (if1.slave)
   );

   // Output monitor state, one slot per instance.
   logic [7:0]  ob [2][0:1023];
   int          ob_n [2];
   int          ob_rd [2];
   int          mstart [2];
   rec_t        rq [2][0:63];
   int          rq_n [2];
   int          rq_rd [2];
   int          rem [2];
   logic [31:0] msz [2];
   int          ra [2];
   int          rb [2];
   int          tsv [2];
   int          tds [2];
   int          overlap = 0;
   int          ndone0 = 0;
   int          ck_t0 = -1;
   vec_t        tbl [5];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=0x%0h expected=0x%0h", nm, act, exp);
      end
   endtask

   task automatic mon(input int u, input logic sv, input logic [31:0] sz, input logic ds,
                      input logic [7:0] d);
      rec_t r;
      if (rst) begin
         rem[u]  = 0;
         ob_n[u] = mstart[u];
         return;
      end
      if (sv && ds) overlap++;
      if (sv) begin
         msz[u] = sz;
         tsv[u] = cyc;
      end
      if (ds) begin
         rem[u]  = int'(msz[u]);
         ra[u]   = 1;
         rb[u]   = 0;
         tds[u]  = cyc;
         ob_n[u] = mstart[u];
      end
      if (rem[u] > 0) begin
         if (ob_n[u] < 1024) ob[u][ob_n[u]] = d;
         ob_n[u]++;
         ra[u] = (ra[u] + int'(d)) % 65521;
         rb[u] = (rb[u] + ra[u]) % 65521;
         rem[u]--;
         if (rem[u] == 0) begin
            r.size  = msz[u];
            r.ck    = {rb[u][15:0], ra[u][15:0]};
            r.t_sv  = tsv[u];
            r.t_ds  = tds[u];
            r.t_end = cyc;
            if (rq_n[u] < 64) rq[u][rq_n[u]] = r;
            rq_n[u]++;
            mstart[u] = ob_n[u];
            if (u == 0) ndone0++;
         end
      end
   endtask

   always @(negedge clk) begin
      mon(0, if0.size_valid, if0.size, if0.data_start, if0.data);
      mon(1, if1.size_valid, if1.size, if1.data_start, if1.data);
   end

   // Adler32 stand-in for u0: strobe checksum_valid a few cycles after each message.
   initial begin
      int served;
      served = 0;
      if0.checksum_valid = 1'b0;
      forever begin
         @(negedge clk);
         if (ndone0 > served) begin
            served = ndone0;
            repeat (3) @(negedge clk);
            if0.checksum_valid = 1'b1;
            ck_t0 = cyc;
            @(negedge clk);
            if0.checksum_valid = 1'b0;
         end
      end
   end

   task automatic drive(input int u, input logic v, input logic [7:0] d, input logic l);
      if (u == 0) begin
         if0.in_valid = v; if0.in_data = d; if0.in_last = l;
      end else begin
         if1.in_valid = v; if1.in_data = d; if1.in_last = l;
      end
   endtask

   task automatic idle();
      drive(0, 1'b0, 8'h00, 1'b0);
      drive(1, 1'b0, 8'h00, 1'b0);
   endtask

   // Offer one byte until accepted; returns acceptance cycle and the trunc seen then.
   task automatic put(input int u, input logic [7:0] d, input logic l, input int pct,
                      output int t_acc, output logic tr);
      logic v, r;
      t_acc = -1;
      tr    = 1'b0;
      for (int k = 0; k < 500; k++) begin
         v = (pct >= 100) || ($urandom_range(0, 99) < pct);
         drive(u, v, d, l);
         #1;
         r  = (u == 0) ? if0.in_ready : if1.in_ready;
         tr = (u == 0) ? if0.trunc : if1.trunc;
         @(posedge clk); #1;
         if (v && r) begin
            t_acc = cyc - 1;
            return;
         end
      end
      checks++;
      failures++;
      $display("FAIL put_timeout u%0d: byte 0x%02h not accepted in 500 cycles", u, d);
   endtask

   task automatic send(input int u, input string s, input int pct,
                       output int t_first, output int t_last);
      int t;
      logic tr;
      t_first = -1;
      t_last  = -1;
      for (int i = 0; i < s.len(); i++) begin
         put(u, s[i], (i == s.len() - 1), pct, t, tr);
         if (i == 0) t_first = t;
         t_last = t;
      end
   endtask

   task automatic get_rec(input int u, output rec_t r);
      for (int k = 0; k < 400 && rq_rd[u] >= rq_n[u]; k++) begin
         @(posedge clk); #1;
      end
      r = '{default: 0};
      if (rq_rd[u] >= rq_n[u]) begin
         checks++;
         failures++;
         $display("FAIL rec_timeout u%0d: no framed message within 400 cycles", u);
         return;
      end
      r = rq[u][rq_rd[u]];
      rq_rd[u]++;
   endtask

   task automatic chk_byte(input int u, input string nm, input logic [7:0] exp);
      logic [7:0] act;
      act = (ob_rd[u] < ob_n[u] && ob_rd[u] < 1024) ? ob[u][ob_rd[u]] : 8'hxx;
      chk(nm, act, exp);
      ob_rd[u]++;
   endtask

   task automatic chk_str(input int u, input string nm, input string s);
      for (int i = 0; i < s.len(); i++) chk_byte(u, $sformatf("%s_b%0d", nm, i), s[i]);
   endtask

   task automatic wait_ready(input int u, output int t);
      t = -1;
      for (int k = 0; k < 400; k++) begin
         if ((u == 0) ? if0.in_ready : if1.in_ready) begin
            t = cyc;
            return;
         end
         @(posedge clk); #1;
      end
      checks++;
      failures++;
      $display("FAIL ready_timeout u%0d: in_ready did not return in 400 cycles", u);
   endtask

   task automatic chk_rst_state(input string nm);
      chk({nm, "_in_ready"},   if0.in_ready, 1);
      chk({nm, "_busy"},       if0.busy, 0);
      chk({nm, "_size_valid"}, if0.size_valid, 0);
      chk({nm, "_size"},       if0.size, 0);
      chk({nm, "_data_start"}, if0.data_start, 0);
      chk({nm, "_data"},       if0.data, 0);
      chk({nm, "_trunc"},      if0.trunc, 0);
      chk({nm, "_u1_ready"},   if1.in_ready, 1);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rec_t r;
      int   tf, tl, tr_c, t_abc, t3, t_ds;
      logic tr;
      logic [7:0] b;
      string m;

      tbl[0] = '{"a",         100, 32'd1, 32'h0062_0062};
      tbl[1] = '{"abc",       100, 32'd3, 32'h024D_0127};
      tbl[2] = '{"Wikipedia", 100, 32'd9, 32'h11E6_0398};
      tbl[3] = '{"abc",        50, 32'd3, 32'h024D_0127};
      tbl[4] = '{"Wikipedia",  50, 32'd9, 32'h11E6_0398};

      rst = 1'b1;
      idle();
      if1.checksum_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_rst_state("reset");
      rst = 1'b0;
      @(posedge clk); #1;

      // Table: single messages on u0, each followed by the checksum handshake.
      for (int i = 0; i < 5; i++) begin
         m = tbl[i].msg;
         send(0, m, tbl[i].pct, tf, tl);
         idle();
         get_rec(0, r);
         chk($sformatf("v%0d_size", i), r.size, tbl[i].size);
         chk($sformatf("v%0d_cksum", i), r.ck, tbl[i].ck);
         chk($sformatf("v%0d_lat_size", i), r.t_sv, tl + 1);
         chk($sformatf("v%0d_lat_start", i), r.t_ds, tl + 2);
         chk($sformatf("v%0d_lat_end", i), r.t_end, tl + 1 + int'(tbl[i].size));
         chk_str(0, $sformatf("v%0d", i), m);
         chk($sformatf("v%0d_hold_data", i), if0.data, m[m.len() - 1]);
         chk($sformatf("v%0d_hold_size", i), if0.size, tbl[i].size);
         chk($sformatf("v%0d_busy_wait", i), if0.busy, 1);
         wait_ready(0, tr_c);
         chk($sformatf("v%0d_ready_after_ck", i), tr_c, ck_t0 + 1);
      end

      // Back to back: the second message is held off until the first checksum returns.
      send(0, "Wikipedia", 100, tf, tl);
      send(0, "abc", 100, t_abc, tl);
      idle();
      chk("b2b_first_accept", t_abc, ck_t0 + 1);
      get_rec(0, r);
      chk("b2b_m0_size", r.size, 9);
      chk("b2b_m0_cksum", r.ck, 32'h11E6_0398);
      chk_str(0, "b2b_m0", "Wikipedia");
      get_rec(0, r);
      chk("b2b_m1_size", r.size, 3);
      chk("b2b_m1_cksum", r.ck, 32'h024D_0127);
      chk_str(0, "b2b_m1", "abc");
      wait_ready(0, tr_c);

      // Reset during the second data cycle of a 5-byte message.
      send(0, "hello", 100, tf, tl);
      idle();
      t_ds = -1;
      for (int k = 0; k < 50 && !if0.data_start; k++) begin
         @(posedge clk); #1;
      end
      if (if0.data_start) t_ds = cyc;
      chk("midrst_start_cycle", t_ds, tl + 2);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk_rst_state("midrst");
      send(0, "Z", 100, tf, tl);
      idle();
      get_rec(0, r);
      chk("postrst_size", r.size, 1);
      chk("postrst_cksum", r.ck, 32'h005B_005B);
      chk("postrst_lat_start", r.t_ds, tl + 2);
      chk_str(0, "postrst", "Z");
      wait_ready(0, tr_c);

      // u1: 6 bytes into a 4-byte buffer force-close after byte 3.
      t3 = -1;
      for (int i = 0; i < 6; i++) begin
         b = 8'h10 + 8'(i);
         put(1, b, (i == 5), 100, tf, tr);
         if (i == 2) chk("trunc_byte2", tr, 0);
         if (i == 3) begin
            chk("trunc_byte3", tr, 1);
            t3 = tf;
         end
         if (i == 5) chk("trunc_byte5", tr, 0);
      end
      idle();
      get_rec(1, r);
      chk("trunc_m0_size", r.size, 4);
      chk("trunc_m0_cksum", r.ck, 32'h00AE_0047);
      chk("trunc_m0_lat_size", r.t_sv, t3 + 1);
      for (int i = 0; i < 4; i++) chk_byte(1, $sformatf("trunc_m0_b%0d", i), 8'h10 + 8'(i));
      get_rec(1, r);
      chk("trunc_m1_size", r.size, 2);
      chk("trunc_m1_cksum", r.ck, 32'h003F_002A);
      for (int i = 0; i < 2; i++) chk_byte(1, $sformatf("trunc_m1_b%0d", i), 8'h14 + 8'(i));
      wait_ready(1, tr_c);

      // u1: GAP=3 idle cycles, no checksum wait.
      send(1, "abc", 100, tf, tl);
      idle();
      get_rec(1, r);
      chk("gap_size", r.size, 3);
      chk("gap_cksum", r.ck, 32'h024D_0127);
      chk("gap_busy", if1.busy, 1);
      chk_str(1, "gap", "abc");
      wait_ready(1, tr_c);
      chk("gap_ready_cycle", tr_c, tl + 2 + 3 + 3);

      chk("size_start_exclusive", overlap, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
